// File: rtl/motor_feedback_supervisor.sv
// Contactor feedback supervisor: checks that each motor's aux-contact feedback follows its
// run command within a time window, and latches start/stop/loss/weld faults until acknowledged.

module mfs_debounce #(
   parameter int DB_CYC = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);
   localparam int CW = $clog2(DB_CYC + 1);

   logic          s1, s2;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser, then the level moves only after DB_CYC agreeing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         cnt  <= '0;
         dout <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 == dout) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYC - 1)) begin
            cnt  <= '0;
            dout <= s2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module mfs_motor #(
   parameter int T_ON_CYC  = 2000,
   parameter int T_OFF_CYC = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd,
   input  logic       fb,
   input  logic       ack_p,
   output logic       run,
   output logic       fault,
   output logic [1:0] fcode
);
   localparam int TMAX = (T_ON_CYC > T_OFF_CYC) ? T_ON_CYC : T_OFF_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] TON  = TW'(T_ON_CYC);
   localparam logic [TW-1:0] TOFF = TW'(T_OFF_CYC);

   typedef enum logic [2:0] {IDLE, STARTING, RUNNING, STOPPING, FAULT} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [1:0]    code;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
         code  <= 2'b00;
         run   <= 1'b0;
         fault <= 1'b0;
         fcode <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (cmd) begin
                  state <= STARTING;
                  timer <= TON;
               end else if (fb) begin
                  state <= FAULT;
                  code  <= 2'b10;
               end
            end
            STARTING: begin
               if (fb) begin
                  state <= RUNNING;
               end else if (!cmd) begin
                  state <= STOPPING;
                  timer <= TOFF;
               end else if (timer == '0) begin
                  state <= FAULT;
                  code  <= 2'b01;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            RUNNING: begin
               // A stop command masks a simultaneous feedback loss.
               if (!cmd) begin
                  state <= STOPPING;
                  timer <= TOFF;
               end else if (!fb) begin
                  state <= FAULT;
                  code  <= 2'b11;
               end
            end
            STOPPING: begin
               if (!fb && !cmd) begin
                  state <= IDLE;
               end else if (cmd && fb) begin
                  state <= RUNNING;
               end else if (cmd) begin
                  state <= STARTING;
                  timer <= TON;
               end else if (timer == '0) begin
                  state <= FAULT;
                  code  <= 2'b10;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            FAULT: begin
               if (ack_p && !cmd && !fb) begin
                  state <= IDLE;
                  code  <= 2'b00;
               end
            end
            default: begin
               state <= IDLE;
               code  <= 2'b00;
            end
         endcase
         run   <= (state == RUNNING);
         fault <= (state == FAULT);
         fcode <= code;
      end
   end
endmodule

module motor_feedback_supervisor #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int T_ON_MS  = 500,
   parameter int T_OFF_MS = 500,
   parameter int DB_MS    = 10,
   parameter int BLINK_HZ = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_m1,
   input  logic       cmd_m2,
   input  logic       fb_m1,
   input  logic       fb_m2,
   input  logic       ack,
   output logic       run_m1,
   output logic       run_m2,
   output logic       fault_m1,
   output logic       fault_m2,
   output logic [1:0] fcode_m1,
   output logic [1:0] fcode_m2,
   output logic       alarm,
   output logic       interlock
);
   localparam int NUM_M     = 2;
   localparam int DB_CYC    = CLK_HZ / 1000 * DB_MS;
   localparam int T_ON_CYC  = CLK_HZ / 1000 * T_ON_MS;
   localparam int T_OFF_CYC = CLK_HZ / 1000 * T_OFF_MS;
   localparam int HALF      = CLK_HZ / (2 * BLINK_HZ);
   localparam int BW        = $clog2(HALF + 1);

   logic [NUM_M-1:0]      cmd, fb_raw, fb_db, run, fault;
   logic [NUM_M-1:0][1:0] fcode;
   logic                  ack_db, ack_db_q, ack_p;
   logic [BW-1:0]         blink_cnt;
   logic                  phase;

   assign cmd    = {cmd_m2, cmd_m1};
   assign fb_raw = {fb_m2, fb_m1};

   mfs_debounce #(.DB_CYC(DB_CYC)) u_ack_db (
      .clk(clk), .rst_n(rst_n), .din(ack), .dout(ack_db)
   );

   assign ack_p = ack_db & ~ack_db_q;

   for (genvar i = 0; i < NUM_M; i++) begin : g_m
      mfs_debounce #(.DB_CYC(DB_CYC)) u_db (
         .clk(clk), .rst_n(rst_n), .din(fb_raw[i]), .dout(fb_db[i])
      );
      mfs_motor #(.T_ON_CYC(T_ON_CYC), .T_OFF_CYC(T_OFF_CYC)) u_motor (
         .clk(clk), .rst_n(rst_n), .cmd(cmd[i]), .fb(fb_db[i]), .ack_p(ack_p),
         .run(run[i]), .fault(fault[i]), .fcode(fcode[i])
      );
   end

   assign run_m1   = run[0];
   assign run_m2   = run[1];
   assign fault_m1 = fault[0];
   assign fault_m2 = fault[1];
   assign fcode_m1 = fcode[0];
   assign fcode_m2 = fcode[1];

   // Blink phase runs free so the lamp cadence is independent of fault timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_db_q  <= 1'b0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         alarm     <= 1'b0;
         interlock <= 1'b0;
      end else begin
         ack_db_q <= ack_db;
         if (blink_cnt == BW'(HALF - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         alarm     <= (|fault) & phase;
         interlock <= &run;
      end
   end
endmodule

// File: tb/tb_motor_feedback_supervisor.sv
// Directed bench for motor_feedback_supervisor at reduced clock rate (200-cycle debounce,
// 2000-cycle windows, 1000-cycle blink half-period).

module tb_motor_feedback_supervisor;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_m1 = 1'b0, cmd_m2 = 1'b0, fb_m1 = 1'b0, fb_m2 = 1'b0, ack = 1'b0;
   logic       run_m1, run_m2, fault_m1, fault_m2, alarm, interlock;
   logic [1:0] fcode_m1, fcode_m2;

   int checks = 0;
   int failures = 0;
   int il_cnt, flt_cnt;

   motor_feedback_supervisor #(
      .CLK_HZ(100_000), .T_ON_MS(20), .T_OFF_MS(20), .DB_MS(2), .BLINK_HZ(50)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_m1(cmd_m1), .cmd_m2(cmd_m2), .fb_m1(fb_m1),
      .fb_m2(fb_m2), .ack(ack), .run_m1(run_m1), .run_m2(run_m2), .fault_m1(fault_m1),
      .fault_m2(fault_m2), .fcode_m1(fcode_m1), .fcode_m2(fcode_m2), .alarm(alarm),
      .interlock(interlock)
   );

   always #5 clk = ~clk;

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cmd_m1 = 1'b0; cmd_m2 = 1'b0; fb_m1 = 1'b0; fb_m2 = 1'b0; ack = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
   endtask

   task automatic watch(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (interlock) il_cnt++;
         if (fault_m1 || fault_m2) flt_cnt++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      wait_cyc(2);
      checks++; if ({run_m1, run_m2, fault_m1, fault_m2} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {run_m1, run_m2, fault_m1, fault_m2}); end
      checks++; if ({fcode_m1, fcode_m2} !== 4'b0) begin failures++; $display("FAIL reset_fcode got=%b exp=0000", {fcode_m1, fcode_m2}); end
      checks++; if ({alarm, interlock} !== 2'b0) begin failures++; $display("FAIL reset_alarm_il got=%b exp=00", {alarm, interlock}); end
   endtask

   task automatic test_start_bounce();
      do_reset();
      cmd_m1 = 1'b1;
      for (int i = 0; i < 500; i++) begin
         fb_m1 = ((i / 7) % 2) != 0;
         @(negedge clk);
      end
      checks++; if (run_m1 !== 1'b0) begin failures++; $display("FAIL bounce_not_run got=%b exp=0", run_m1); end
      fb_m1 = 1'b1;
      wait_cyc(300);
      checks++; if (run_m1 !== 1'b1) begin failures++; $display("FAIL start_run_m1 got=%b exp=1", run_m1); end
      checks++; if ({fault_m1, fcode_m1} !== 3'b000) begin failures++; $display("FAIL start_fault_m1 got=%b exp=000", {fault_m1, fcode_m1}); end
   endtask

   task automatic test_no_start();
      logic prev;
      int   n;
      do_reset();
      cmd_m1 = 1'b1;
      wait_cyc(1990);
      checks++; if (fault_m1 !== 1'b0) begin failures++; $display("FAIL nostart_early got=%b exp=0", fault_m1); end
      wait_cyc(20);
      checks++; if ({fault_m1, fcode_m1} !== 3'b101) begin failures++; $display("FAIL nostart_fault got=%b exp=101", {fault_m1, fcode_m1}); end
      prev = alarm; n = 0;
      while (alarm === prev && n < 1100) begin @(negedge clk); n++; end
      checks++; if (n >= 1100) begin failures++; $display("FAIL alarm_toggle1 got=%0d exp=<1100", n); end
      prev = alarm; n = 0;
      while (alarm === prev && n < 1100) begin @(negedge clk); n++; end
      checks++; if (n != 1000) begin failures++; $display("FAIL alarm_period got=%0d exp=1000", n); end
   endtask

   task automatic test_lost();
      do_reset();
      cmd_m2 = 1'b1; fb_m2 = 1'b1;
      wait_cyc(400);
      checks++; if (run_m2 !== 1'b1) begin failures++; $display("FAIL lost_run_m2 got=%b exp=1", run_m2); end
      fb_m2 = 1'b0;
      wait_cyc(300);
      fb_m2 = 1'b1;
      wait_cyc(20);
      checks++; if ({fault_m2, fcode_m2} !== 3'b111) begin failures++; $display("FAIL lost_fault got=%b exp=111", {fault_m2, fcode_m2}); end
      wait_cyc(300);
      ack = 1'b1; wait_cyc(300);
      ack = 1'b0; wait_cyc(300);
      checks++; if ({fault_m2, fcode_m2} !== 3'b111) begin failures++; $display("FAIL ack_cmd_high got=%b exp=111", {fault_m2, fcode_m2}); end
      cmd_m2 = 1'b0; fb_m2 = 1'b0;
      wait_cyc(300);
      ack = 1'b1; wait_cyc(300);
      checks++; if ({fault_m2, fcode_m2, alarm} !== 4'b0000) begin failures++; $display("FAIL ack_clear got=%b exp=0000", {fault_m2, fcode_m2, alarm}); end
      ack = 1'b0; wait_cyc(300);
   endtask

   task automatic test_weld();
      do_reset();
      cmd_m1 = 1'b1; fb_m1 = 1'b1;
      wait_cyc(400);
      cmd_m1 = 1'b0;
      wait_cyc(1990);
      checks++; if ({run_m1, fault_m1} !== 2'b00) begin failures++; $display("FAIL weld_stopping got=%b exp=00", {run_m1, fault_m1}); end
      wait_cyc(20);
      checks++; if ({fault_m1, fcode_m1} !== 3'b110) begin failures++; $display("FAIL weld_fault got=%b exp=110", {fault_m1, fcode_m1}); end
      do_reset();
      fb_m1 = 1'b1;
      wait_cyc(250);
      checks++; if ({fault_m1, fcode_m1} !== 3'b110) begin failures++; $display("FAIL idle_weld got=%b exp=110", {fault_m1, fcode_m1}); end
   endtask

   task automatic test_alternation();
      do_reset();
      il_cnt = 0; flt_cnt = 0;
      cmd_m1 = 1'b1; fb_m1 = 1'b1;
      watch(400);
      cmd_m2 = 1'b1;
      watch(500);
      checks++; if (interlock !== 1'b0) begin failures++; $display("FAIL alt_il_before got=%b exp=0", interlock); end
      fb_m2 = 1'b1;
      watch(300);
      checks++; if (interlock !== 1'b1) begin failures++; $display("FAIL alt_il_overlap got=%b exp=1", interlock); end
      cmd_m1 = 1'b0;
      watch(500);
      checks++; if ({interlock, run_m1} !== 2'b00) begin failures++; $display("FAIL alt_il_after got=%b exp=00", {interlock, run_m1}); end
      fb_m1 = 1'b0;
      watch(400);
      checks++; if ({run_m1, run_m2} !== 2'b01) begin failures++; $display("FAIL alt_final_run got=%b exp=01", {run_m1, run_m2}); end
      checks++; if (flt_cnt != 0) begin failures++; $display("FAIL alt_faults got=%0d exp=0", flt_cnt); end
      checks++; if (il_cnt < 90 || il_cnt > 110) begin failures++; $display("FAIL alt_il_len got=%0d exp=90..110", il_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fb_m1 = 1'b1; fb_m2 = 1'b1;
      wait_cyc(300);
      checks++; if ({fault_m1, fault_m2} !== 2'b11) begin failures++; $display("FAIL mid_both_fault got=%b exp=11", {fault_m1, fault_m2}); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({run_m1, run_m2, fault_m1, fault_m2, fcode_m1, fcode_m2, alarm, interlock} !== 10'b0) begin
         failures++; $display("FAIL mid_async_clear got=%b exp=0", {run_m1, run_m2, fault_m1, fault_m2, fcode_m1, fcode_m2, alarm, interlock}); end
      fb_m1 = 1'b0; fb_m2 = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(10);
      checks++; if ({fault_m1, fault_m2, fcode_m1, fcode_m2, alarm} !== 7'b0) begin failures++; $display("FAIL mid_after got=%b exp=0", {fault_m1, fault_m2, fcode_m1, fcode_m2, alarm}); end
   endtask

   initial begin
      test_reset();
      test_start_bounce();
      test_no_start();
      test_lost();
      test_weld();
      test_alternation();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
